// File: rtl/dmem_seq.sv
// dmem_seq: parametrised data memory loaded with a default image by a one-word-per-clock sequencer.
// Define DMEM_WR_FWD_EN to make a same-cycle read and write of one in-range address return the write data.
module dmem_seq #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          init_req,
    input  logic [AW-1:0] mem_a,
    input  logic          mem_re,
    input  logic          mem_we,
    input  logic [DW-1:0] mem_wd,
    output logic [DW-1:0] mem_rd,
    output logic          mem_rvalid,
    output logic          mem_err,
    output logic          busy,
    output logic          init_done
);
    typedef enum logic {INIT, IDLE} state_t;
    state_t state, state_d;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr, wr_a, rd_a;
    logic [DW-1:0] img, wr_d, ram_q, wd_q;
    logic [31:0]   pi;
    logic          in_range, last, acc, rd_en, wr_en, fwd, fwd_q, oor_q;
    assign in_range = {1'b0, mem_a} < (AW+1)'(DEPTH);
    assign last     = ptr == AW'(DEPTH-1);
    assign acc      = state == IDLE && !init_req && !clr;
    assign rd_en    = acc && mem_re;
    assign rd_a     = in_range ? mem_a : '0;
    assign busy     = state == INIT;
    assign pi       = 32'(ptr);
    assign img      = pi < 32'(DEPTH/2) ? DW'(pi) : DW'(32'(DEPTH/2) - pi);
`ifdef DMEM_WR_FWD_EN
    assign fwd = mem_we && in_range;
`else
    assign fwd = 1'b0;
`endif
    always_comb begin
        state_d = state;
        wr_en   = 1'b0;
        wr_a    = ptr;
        wr_d    = img;
        state_d = state == INIT ? (last ? IDLE : INIT) : (init_req ? INIT : IDLE);
        wr_en   = state == INIT ? !clr : acc && mem_we && in_range;
        wr_a    = state == INIT ? ptr : mem_a;
        wr_d    = state == INIT ? img : mem_wd;
    end
    // array has no reset so it maps onto RAM; the sequencer fills it instead
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_a] <= wr_d;
        if (rd_en) ram_q <= mem[rd_a];
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= INIT;
            ptr        <= '0;
            init_done  <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_err    <= 1'b0;
            oor_q      <= 1'b0;
            fwd_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            state      <= state_d;
            ptr        <= (state == INIT && !last) ? ptr + 1'b1 : '0;
            init_done  <= init_done || (state == INIT && last);
            mem_rvalid <= rd_en;
            mem_err    <= acc && (mem_re || mem_we) && !in_range;
            oor_q      <= !in_range;
            fwd_q      <= fwd;
            wd_q       <= mem_wd;
        end
    end
    assign mem_rd = (!mem_rvalid || oor_q) ? '0 : fwd_q ? wd_q : ram_q;
endmodule

// File: tb/tb_dmem_seq.sv
// tb_dmem_seq: scoreboard bench driving a DEPTH=32 and a DEPTH=24 instance with shared stimulus.
module tb_dmem_seq;
    logic       clk = 0, clr = 1, init_req = 0, re = 0, we = 0;
    logic [4:0] a = '0;
    logic [7:0] wd = '0;
    logic [7:0] rd_a, rd_b;
    logic       rv_a, rv_b, err_a, err_b, busy_a, busy_b, done_a, done_b;
    int         tests = 0, fails = 0, cyc = 0;
    bit         live = 0;
`ifdef DMEM_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct {int cyc; logic [7:0] rd; logic rv; logic err;} exp_t;
    exp_t qa[$], qb[$];

    dmem_seq #(.DW(8), .AW(5), .DEPTH(32)) dut_a (
        .clk(clk), .clr(clr), .init_req(init_req), .mem_a(a), .mem_re(re), .mem_we(we),
        .mem_wd(wd), .mem_rd(rd_a), .mem_rvalid(rv_a), .mem_err(err_a), .busy(busy_a),
        .init_done(done_a));
    dmem_seq #(.DW(8), .AW(5), .DEPTH(24)) dut_b (
        .clk(clk), .clr(clr), .init_req(init_req), .mem_a(a), .mem_re(re), .mem_we(we),
        .mem_wd(wd), .mem_rd(rd_b), .mem_rvalid(rv_b), .mem_err(err_b), .busy(busy_b),
        .init_done(done_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic push(bit b, logic [7:0] rd, logic rv, logic err);
        exp_t e;
        e.cyc = cyc + 1;
        e.rd  = rd;
        e.rv  = rv;
        e.err = err;
        if (b) qb.push_back(e);
        else qa.push_back(e);
    endtask

    task automatic mon(bit b, logic rv, logic err, logic [7:0] rd);
        string n = b ? "b" : "a";
        exp_t  e;
        int    sz = b ? qb.size() : qa.size();
        if (sz != 0) begin
            e = b ? qb[0] : qa[0];
            if (e.cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s_missing: no response, expected rd=%0h err=%0b for cycle %0d", n, e.rd, e.err, e.cyc);
                if (b) e = qb.pop_front();
                else e = qa.pop_front();
                sz--;
            end
        end
        if (rv || err) begin
            if (sz == 0) begin
                tests++;
                fails++;
                $display("FAIL %s_unexpected: rvalid=%0b err=%0b rd=%0h, expected none", n, rv, err, rd);
            end else begin
                if (b) e = qb.pop_front();
                else e = qa.pop_front();
                chk({n, "_rd"}, 32'(rd), 32'(e.rd));
                chk({n, "_rvalid"}, 32'(rv), 32'(e.rv));
                chk({n, "_err"}, 32'(err), 32'(e.err));
                chk({n, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end else chk({n, "_rd_idle"}, 32'(rd), 32'h0);
    endtask

    always @(negedge clk) if (live) begin
        mon(1'b0, rv_a, err_a, rd_a);
        mon(1'b1, rv_b, err_b, rd_b);
    end

    task automatic rd(logic [4:0] ad, logic [7:0] ea, logic [7:0] eb, logic erb);
        a = ad; re = 1; we = 0;
        push(1'b0, ea, 1'b1, 1'b0);
        push(1'b1, eb, 1'b1, erb);
        @(negedge clk);
        re = 0;
    endtask

    task automatic wr(logic [4:0] ad, logic [7:0] d, logic erb);
        a = ad; wd = d; we = 1; re = 0;
        if (erb) push(1'b1, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        we = 0;
    endtask

    task automatic rw(logic [4:0] ad, logic [7:0] d, logic [7:0] ea, logic [7:0] eb, logic erb);
        a = ad; wd = d; we = 1; re = 1;
        push(1'b0, ea, 1'b1, 1'b0);
        push(1'b1, eb, 1'b1, erb);
        @(negedge clk);
        we = 0; re = 0;
    endtask

    // entered on the first falling edge after the edge that started the load
    task automatic do_init(bit poke, bit redo);
        for (int k = 1; k <= 33; k++) begin
            chk("busy_a", 32'(busy_a), 32'(k <= 32));
            chk("busy_b", 32'(busy_b), 32'(k <= 24));
            chk("done_a", 32'(done_a), 32'(redo || k > 32));
            chk("done_b", 32'(done_b), 32'(redo || k > 24));
            if (poke && k == 5) begin
                a = 5'd3; wd = 8'h77; re = 1; we = 1;
            end
            @(negedge clk);
            re = 0; we = 0;
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_rvalid", 32'({rv_a, rv_b}), 32'h0);
        chk("rst_err", 32'({err_a, err_b}), 32'h0);
        chk("rst_rd", 32'({rd_a, rd_b}), 32'h0);
        live = 1;
        clr  = 0;
        do_init(1'b1, 1'b0);
        rd(5'd0, 8'h00, 8'h00, 1'b0);
        rd(5'd15, 8'h0f, 8'hfd, 1'b0);
        rd(5'd16, 8'h00, 8'hfc, 1'b0);
        rd(5'd17, 8'hff, 8'hfb, 1'b0);
        rd(5'd31, 8'hf1, 8'h00, 1'b1);
        rd(5'd3, 8'h03, 8'h03, 1'b0);
        rd(5'd11, 8'h0b, 8'h0b, 1'b0);
        rd(5'd12, 8'h0c, 8'h00, 1'b0);
        rd(5'd23, 8'hf9, 8'hf5, 1'b0);
        rd(5'd24, 8'hf8, 8'h00, 1'b1);
        @(negedge clk);
        wr(5'd5, 8'ha5, 1'b0);
        rd(5'd5, 8'ha5, 8'ha5, 1'b0);
        repeat (2) @(negedge clk);
        rw(5'd9, 8'h3c, FWD ? 8'h3c : 8'h09, FWD ? 8'h3c : 8'h09, 1'b0);
        rd(5'd9, 8'h3c, 8'h3c, 1'b0);
        @(negedge clk);
        wr(5'd30, 8'h11, 1'b1);
        rd(5'd30, 8'h11, 8'h00, 1'b1);
        wr(5'd23, 8'h5a, 1'b0);
        rd(5'd23, 8'h5a, 8'h5a, 1'b0);
        rw(5'd28, 8'hc3, FWD ? 8'hc3 : 8'hf4, 8'h00, 1'b1);
        rd(5'd28, 8'hc3, 8'h00, 1'b1);
        wr(5'd4, 8'hee, 1'b0);
        @(negedge clk);
        // clr with a same-cycle read, then clr again when the sequencer reaches word 10
        clr = 1; re = 1; a = 5'd5;
        @(negedge clk);
        clr = 0; re = 0;
        repeat (10) @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        do_init(1'b0, 1'b0);
        rd(5'd4, 8'h04, 8'h04, 1'b0);
        rd(5'd9, 8'h09, 8'h09, 1'b0);
        wr(5'd7, 8'h77, 1'b0);
        init_req = 1; re = 1; we = 1; a = 5'd6; wd = 8'h66;
        @(negedge clk);
        init_req = 0; re = 0; we = 0;
        do_init(1'b0, 1'b1);
        rd(5'd6, 8'h06, 8'h06, 1'b0);
        rd(5'd7, 8'h07, 8'h07, 1'b0);
        rd(5'd5, 8'h05, 8'h05, 1'b0);
        repeat (3) @(negedge clk);
        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
